// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU
// load/store path (port 0) and a DMA/loader engine (port 1). One access per
// cycle, starvation protection for port 1, bounded burst lock for port 1,
// and read-return routing across the memory's one-cycle read latency.
module data_mem_arbiter #(
  parameter int ADDR_WIDTH   = 10,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4,
  parameter int LOCK_MAX     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic                  lock1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic                  stall0,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  output logic                  mem_re,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int LW = $clog2(LOCK_MAX + 1);
  localparam logic [SW-1:0] C_STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [LW-1:0] C_LOCK_MAX   = LW'(LOCK_MAX);

  typedef enum logic {ARB, DMA_LOCK} arbState_t;

  arbState_t       r_state;
  arbState_t       w_nextState;
  logic [SW-1:0]   r_starveCnt;
  logic [SW-1:0]   w_starveNext;
  logic [LW-1:0]   r_lockCnt;
  logic [LW-1:0]   w_lockNext;
  logic            w_arbGnt1;
  logic            w_gnt0;
  logic            w_gnt1;
  logic            r_rdValid;
  logic            r_rdOwner;

  // State and counter registers; reset discards any in-flight lock or starvation history.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ARB;
      r_starveCnt <= '0;
      r_lockCnt   <= '0;
    end else begin
      r_state     <= w_nextState;
      r_starveCnt <= w_starveNext;
      r_lockCnt   <= w_lockNext;
    end
  end

  // Grant decision and next state; the lock counter saturates at LOCK_MAX so an idle CPU cannot push it past the forced-exit point.
  always_comb begin
    w_gnt0      = 1'b0;
    w_gnt1      = 1'b0;
    w_nextState = r_state;
    w_lockNext  = r_lockCnt;
    w_arbGnt1   = req1 & (~req0 | (r_starveCnt == C_STARVE_MAX));
    case (r_state)
      ARB: begin
        w_gnt1 = w_arbGnt1;
        w_gnt0 = req0 & ~w_arbGnt1;
        if (w_arbGnt1 & lock1) begin
          w_nextState = DMA_LOCK;
          w_lockNext  = LW'(1);
        end
      end
      DMA_LOCK: begin
        if (req0 & (r_lockCnt == C_LOCK_MAX)) begin
          w_gnt0      = 1'b1;
          w_nextState = ARB;
          w_lockNext  = '0;
        end else if (req1 & lock1) begin
          w_gnt1 = 1'b1;
          if (r_lockCnt != C_LOCK_MAX) begin
            w_lockNext = r_lockCnt + LW'(1);
          end
        end else begin
          w_gnt1      = w_arbGnt1;
          w_gnt0      = req0 & ~w_arbGnt1;
          w_nextState = ARB;
          w_lockNext  = '0;
        end
      end
      default: begin
        w_nextState = ARB;
        w_lockNext  = '0;
      end
    endcase
    if (!reset) begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
    end
  end

  // Starvation counter: counts CPU wins while the DMA waits, cleared once the DMA is served or stops asking.
  always_comb begin
    w_starveNext = r_starveCnt;
    if (~req1 | w_gnt1) begin
      w_starveNext = '0;
    end else if (w_gnt0 & (r_starveCnt != C_STARVE_MAX)) begin
      w_starveNext = r_starveCnt + SW'(1);
    end
  end

  // Memory port driven straight from whichever requester won this cycle.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    if (w_gnt1) begin
      mem_addr  = addr1;
      mem_wdata = wdata1;
      mem_we    = we1;
      mem_re    = ~we1;
    end else if (w_gnt0) begin
      mem_addr  = addr0;
      mem_wdata = wdata0;
      mem_we    = we0;
      mem_re    = ~we0;
    end
  end

  // Remember who issued a read so the returning data goes to the right port next cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rdValid <= 1'b0;
      r_rdOwner <= 1'b0;
    end else begin
      r_rdValid <= mem_re;
      r_rdOwner <= w_gnt1;
    end
  end

  assign gnt0    = w_gnt0;
  assign gnt1    = w_gnt1;
  assign stall0  = req0 & ~w_gnt0;
  assign rvalid0 = r_rdValid & ~r_rdOwner;
  assign rvalid1 = r_rdValid & r_rdOwner;
  assign rdata0  = rvalid0 ? mem_rdata : '0;
  assign rdata1  = rvalid1 ? mem_rdata : '0;

endmodule
